uart_apb_ctrl: RTL and testbench

- APB3 register slave that connects the UART's stream side to a CPU bus.
- It consumes the UART receive stream (RX_FIFO reads) and produces the UART transmit stream (TX_FIFO writes).
- It holds the status and control registers defined in `uart_p` and generates the level interrupt.
- It sits between the APB interconnect and the `uart` core's `rx_axis` / `tx_axis` ports.

---
 rtl/uart_p.sv | 41 ++++
 rtl/uart_apb_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_apb_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_p.sv
// uart_p: shared UART definitions -- APB register map, control/status
// register layouts, APB data width and the APB slave FSM state type.
package uart_p;

  localparam int APB_DBITS = 8;
  localparam int PDATA_W   = 32;

  // Byte addresses of the APB-visible registers.
  typedef enum logic [APB_DBITS-1:0] {
    RX_FIFO = 8'h00,
    TX_FIFO = 8'h04,
    STAT_RG = 8'h08,
    CTRL_RG = 8'h0C
  } ua_regs;

  // CTRL_RG write layout (bit 0 is the only readable bit).
  typedef struct packed {
    logic rst_tx_fifo;
    logic rst_rx_fifo;
    logic irq_en;
  } r_ctrl_t;

  // STAT_RG read layout, MSB first.
  typedef struct packed {
    logic rx_fifo_valid;
    logic rx_fifo_full;
    logic tx_fifo_empty;
    logic tx_fifo_full;
    logic irq_en;
    logic overrun_err;
    logic frame_err;
    logic parity_err;
  } r_sts_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TXWAIT,
    ST_RESP
  } apb_state_t;

endpackage

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB3 slave bridging the CPU bus to the UART core's
// rx/tx streams, with sticky error flags, control bits and a level irq.
// Optional feature macro: UART_APB_PSLVERR_EN (error responses, and TX
// writes to a full core fail fast instead of stalling).
module uart_apb_ctrl #(
  parameter int DBITS   = 8,
  parameter int PDATA_W = uart_p::PDATA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [uart_p::APB_DBITS-1:0] paddr,
  input  logic [PDATA_W-1:0]           pwdata,
  output logic [PDATA_W-1:0]           prdata,
  output logic                         pready,
  output logic                         pslverr,
  input  logic                         rx_axis_tvalid,
  output logic                         rx_axis_tready,
  input  logic [DBITS-1:0]             rx_axis_tdata,
  output logic                         tx_axis_tvalid,
  input  logic                         tx_axis_tready,
  output logic [DBITS-1:0]             tx_axis_tdata,
  output logic                         tx_axis_tlast,
  output logic                         tx_axis_tkeep,
  output logic                         tx_axis_tstrb,
  output logic                         tx_axis_tuser,
  output logic                         tx_axis_tid,
  output logic                         tx_axis_tdest,
  input  logic                         rx_fifo_full,
  input  logic                         tx_fifo_empty,
  input  logic                         overrun_err,
  input  logic                         frame_err,
  input  logic                         parity_err,
  output logic                         rst_rx_fifo,
  output logic                         rst_tx_fifo,
  output logic                         irq
);
  import uart_p::*;

  apb_state_t         state_q, state_d;
  logic [PDATA_W-1:0] prdata_q, prdata_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic               tx_tvalid_q, tx_tvalid_d;
  logic [DBITS-1:0]   tx_tdata_q, tx_tdata_d;
  logic               irq_en_q, irq_en_d;
  logic [2:0]         err_q, err_d;
  logic               rst_rx_q, rst_rx_d;
  logic               rst_tx_q, rst_tx_d;
  logic               irq_q, irq_d;
  logic               accept;
  logic               sts_clr;
  logic               bad_access;
  r_sts_t             sts;
  r_ctrl_t            ctrl_wr;
  logic               unused_ok;

  assign accept  = (state_q == ST_IDLE) & psel & penable & ~pready_q;
  assign sts     = r_sts_t'({rx_axis_tvalid, rx_fifo_full, tx_fifo_empty,
                             ~tx_axis_tready, irq_en_q, err_q});
  assign ctrl_wr = r_ctrl_t'(pwdata[2:0]);

  // Sticky flags: a pulse on the same edge as the clearing read wins.
  assign err_d = (sts_clr ? 3'b000 : err_q) | {overrun_err, frame_err, parity_err};
  assign irq_d = irq_en_q & (rx_axis_tvalid | (|err_q));

`ifdef UART_APB_PSLVERR_EN
  assign pslverr_d = bad_access;
`else
  assign pslverr_d = 1'b0;
`endif

  assign unused_ok = ^{pwdata[PDATA_W-1:DBITS], bad_access};

  // Address decode and transfer sequencing: IDLE accepts, TXWAIT holds the
  // stream beat until the core takes it, RESP raises pready for one cycle.
  always_comb begin
    state_d        = state_q;
    prdata_d       = prdata_q;
    pready_d       = 1'b0;
    tx_tvalid_d    = tx_tvalid_q;
    tx_tdata_d     = tx_tdata_q;
    irq_en_d       = irq_en_q;
    rst_rx_d       = 1'b0;
    rst_tx_d       = 1'b0;
    sts_clr        = 1'b0;
    bad_access     = 1'b0;
    rx_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          prdata_d = '0;
          state_d  = ST_RESP;
          pready_d = 1'b1;
          case (paddr)
            RX_FIFO: begin
              if (pwrite) begin
                bad_access = 1'b1;
              end else begin
                rx_axis_tready = rx_axis_tvalid;
                if (rx_axis_tvalid) prdata_d = {{(PDATA_W-DBITS){1'b0}}, rx_axis_tdata};
                else                bad_access = 1'b1;
              end
            end
            TX_FIFO: begin
              if (!pwrite) bad_access = 1'b1;
`ifdef UART_APB_PSLVERR_EN
              else if (!tx_axis_tready) bad_access = 1'b1;
`endif
              else begin
                tx_tdata_d  = pwdata[DBITS-1:0];
                tx_tvalid_d = 1'b1;
                state_d     = ST_TXWAIT;
                pready_d    = 1'b0;
              end
            end
            STAT_RG: begin
              if (pwrite) begin
                bad_access = 1'b1;
              end else begin
                prdata_d = {{(PDATA_W-8){1'b0}}, sts};
                sts_clr  = 1'b1;
              end
            end
            CTRL_RG: begin
              if (pwrite) begin
                irq_en_d = ctrl_wr.irq_en;
                rst_rx_d = ctrl_wr.rst_rx_fifo;
                rst_tx_d = ctrl_wr.rst_tx_fifo;
              end else begin
                prdata_d = {{(PDATA_W-1){1'b0}}, irq_en_q};
              end
            end
            default: bad_access = 1'b1;
          endcase
        end
      end
      ST_TXWAIT: begin
        if (tx_axis_tready) begin
          tx_tvalid_d = 1'b0;
          state_d     = ST_RESP;
          pready_d    = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; every one returns to its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      tx_tvalid_q <= 1'b0;
      tx_tdata_q  <= '0;
      irq_en_q    <= 1'b0;
      err_q       <= 3'b000;
      rst_rx_q    <= 1'b0;
      rst_tx_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      tx_tvalid_q <= tx_tvalid_d;
      tx_tdata_q  <= tx_tdata_d;
      irq_en_q    <= irq_en_d;
      err_q       <= err_d;
      rst_rx_q    <= rst_rx_d;
      rst_tx_q    <= rst_tx_d;
      irq_q       <= irq_d;
    end
  end

  assign prdata         = prdata_q;
  assign pready         = pready_q;
  assign pslverr        = pslverr_q;
  assign tx_axis_tvalid = tx_tvalid_q;
  assign tx_axis_tdata  = tx_tdata_q;
  assign tx_axis_tlast  = 1'b1;
  assign tx_axis_tkeep  = 1'b1;
  assign tx_axis_tstrb  = 1'b1;
  assign tx_axis_tuser  = 1'b0;
  assign tx_axis_tid    = 1'b0;
  assign tx_axis_tdest  = 1'b0;
  assign rst_rx_fifo    = rst_rx_q;
  assign rst_tx_fifo    = rst_tx_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Testbench for uart_apb_ctrl: directed scenarios followed by randomized
// APB traffic, checked against a transaction-level model of the registers.
`timescale 1ns/1ps
module tb_uart_apb_ctrl;
  import uart_p::*;

`ifdef UART_APB_PSLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        rx_axis_tvalid, rx_axis_tready;
  logic [7:0]  rx_axis_tdata;
  logic        tx_axis_tvalid, tx_axis_tready;
  logic [7:0]  tx_axis_tdata;
  logic        tx_axis_tlast, tx_axis_tkeep, tx_axis_tstrb;
  logic        tx_axis_tuser, tx_axis_tid, tx_axis_tdest;
  logic        rx_fifo_full, tx_fifo_empty;
  logic        overrun_err, frame_err, parity_err;
  logic        rst_rx_fifo, rst_tx_fifo, irq;

  uart_apb_ctrl #(.DBITS(8), .PDATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tready(rx_axis_tready), .rx_axis_tdata(rx_axis_tdata),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tready(tx_axis_tready), .tx_axis_tdata(tx_axis_tdata),
    .tx_axis_tlast(tx_axis_tlast), .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tstrb(tx_axis_tstrb),
    .tx_axis_tuser(tx_axis_tuser), .tx_axis_tid(tx_axis_tid), .tx_axis_tdest(tx_axis_tdest),
    .rx_fifo_full(rx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .overrun_err(overrun_err), .frame_err(frame_err), .parity_err(parity_err),
    .rst_rx_fifo(rst_rx_fifo), .rst_tx_fifo(rst_tx_fifo), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic       m_irq_en;
  logic [2:0] m_err;          // {overrun, frame, parity}
  logic [7:0] rx_q[$];        // bytes waiting in the core's receive FIFO
  logic [7:0] tx_seen[$];     // bytes the core accepted from the DUT
  int         rx_pulses = 0, tv_cycles = 0, rst_rx_cnt = 0, rst_tx_cnt = 0;
  logic       rx_hs;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic model_irq();
    return m_irq_en & ((rx_q.size() != 0) | (m_err != 3'b000));
  endfunction

  task automatic rx_drive();
    rx_axis_tvalid = (rx_q.size() != 0);
    rx_axis_tdata  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  // Stream/pulse monitor: samples just before each rising edge, applies the
  // receive-FIFO pop just after it.
  always begin
    @(negedge clk); #3;
    rx_hs = rx_axis_tvalid & rx_axis_tready;
    if (rx_axis_tready) rx_pulses++;
    if (rst_rx_fifo) rst_rx_cnt++;
    if (rst_tx_fifo) rst_tx_cnt++;
    if (tx_axis_tvalid) tv_cycles++;
    if (tx_axis_tvalid && tx_axis_tready) tx_seen.push_back(tx_axis_tdata);
    @(posedge clk); #1;
    if (rx_hs && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      rx_drive();
    end
  end

  // One APB transfer; n counts cycles after the first access cycle until pready.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [2:0] err_mask, output logic [31:0] rdata,
                          output logic slverr, output int n);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    penable = 1'b1;
    {overrun_err, frame_err, parity_err} = err_mask;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      {overrun_err, frame_err, parity_err} = 3'b000;
    end while (!pready && n < 40);
    check_eq("pready_seen", pready, 1'b1);
    rdata = prdata; slverr = pslverr;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    check_eq("pready_drop", pready, 1'b0);
    @(negedge clk);
    check_eq("irq", irq, model_irq());
  endtask

  task automatic push_rx(input logic [7:0] b);
    @(negedge clk);
    rx_q.push_back(b);
    rx_drive();
  endtask

  task automatic pulse_err(input int idx);
    @(negedge clk);
    {overrun_err, frame_err, parity_err} = 3'b001 << idx;
    @(negedge clk);
    {overrun_err, frame_err, parity_err} = 3'b000;
    m_err[idx] = 1'b1;
    settle();
  endtask

  task automatic rd_rx();
    logic [31:0] rd; logic se; int n; logic [31:0] want; bit empty; int p0;
    empty = (rx_q.size() == 0);
    want  = empty ? 32'h0 : {24'h0, rx_q[0]};
    p0    = rx_pulses;
    apb_xfer(1'b0, RX_FIFO, 32'h0, 3'b000, rd, se, n);
    check_eq("rx_rdata", rd, want);
    check_eq("rx_slverr", se, SLVERR_EN & empty);
    check_eq("rx_wait", n, 1);
    check_eq("rx_tready_pulses", rx_pulses - p0, empty ? 0 : 1);
    settle();
  endtask

  task automatic wr_tx(input logic [31:0] d);
    logic [31:0] rd; logic se; int n; int s0;
    s0 = tx_seen.size();
    apb_xfer(1'b1, TX_FIFO, d, 3'b000, rd, se, n);
    check_eq("tx_wait", n, 2);
    check_eq("tx_slverr", se, 1'b0);
    check_eq("tx_beats", tx_seen.size() - s0, 1);
    check_eq("tx_tdata", tx_seen[tx_seen.size()-1], d[7:0]);
    settle();
  endtask

  task automatic rd_stat(input logic [2:0] mask);
    logic [31:0] rd; logic se; int n; logic [31:0] want;
    want = {24'h0, rx_q.size() != 0, rx_fifo_full, tx_fifo_empty, ~tx_axis_tready, m_irq_en, m_err};
    apb_xfer(1'b0, STAT_RG, 32'h0, mask, rd, se, n);
    m_err = mask;
    check_eq("stat_rdata", rd, want);
    check_eq("stat_slverr", se, 1'b0);
    check_eq("stat_wait", n, 1);
    settle();
  endtask

  task automatic wr_ctrl(input logic [2:0] v);
    logic [31:0] rd; logic se; int n; int a0, b0;
    a0 = rst_rx_cnt; b0 = rst_tx_cnt;
    apb_xfer(1'b1, CTRL_RG, {29'h0, v}, 3'b000, rd, se, n);
    m_irq_en = v[0];
    check_eq("ctrl_wr_wait", n, 1);
    check_eq("ctrl_wr_slverr", se, 1'b0);
    settle();
    check_eq("rst_rx_pulse", rst_rx_cnt - a0, v[1]);
    check_eq("rst_tx_pulse", rst_tx_cnt - b0, v[2]);
  endtask

  task automatic rd_ctrl();
    logic [31:0] rd; logic se; int n;
    apb_xfer(1'b0, CTRL_RG, 32'h0, 3'b000, rd, se, n);
    check_eq("ctrl_rdata", rd, {31'h0, m_irq_en});
    check_eq("ctrl_rd_wait", n, 1);
    settle();
  endtask

  // Accesses that must be ignored: kind 0 wr RX, 1 wr STAT, 2 rd TX, 3/4 unmapped.
  task automatic bad_op(input int kind);
    logic [31:0] rd; logic se; int n; logic wr; logic [7:0] a; int p0, s0;
    a  = 8'h10 + 8'($urandom_range(0, 8'hEF));
    wr = (kind == 0 || kind == 1 || kind == 4);
    if (kind == 0) a = RX_FIFO;
    if (kind == 1) a = STAT_RG;
    if (kind == 2) a = TX_FIFO;
    p0 = rx_pulses; s0 = tx_seen.size();
    apb_xfer(wr, a, $urandom, 3'b000, rd, se, n);
    check_eq("bad_rdata", wr ? 32'h0 : rd, 32'h0);
    check_eq("bad_slverr", se, SLVERR_EN);
    check_eq("bad_wait", n, 1);
    check_eq("bad_no_side_effect", (rx_pulses - p0) + (tx_seen.size() - s0), 0);
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic se; int n; int s0, t0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0;
    tx_axis_tready = 1'b1; rx_fifo_full = 1'b0; tx_fifo_empty = 1'b1;
    {overrun_err, frame_err, parity_err} = 3'b000;
    m_irq_en = 1'b0; m_err = 3'b000;
    rx_drive();
    repeat (3) @(negedge clk);
    check_eq("rst_prdata", prdata, 32'h0);
    check_eq("rst_pready", pready, 1'b0);
    check_eq("rst_pslverr", pslverr, 1'b0);
    check_eq("rst_tvalid", tx_axis_tvalid, 1'b0);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_fifo_pulses", {rst_rx_fifo, rst_tx_fifo}, 2'b00);
    check_eq("tx_sideband", {tx_axis_tlast, tx_axis_tkeep, tx_axis_tstrb,
                             tx_axis_tuser, tx_axis_tid, tx_axis_tdest}, 6'b111000);
    rst_n = 1'b1;
    @(negedge clk);

    // TX write with the core ready.
    wr_tx(32'h000000A5);

    // TX write while the core is full for a while.
    tx_axis_tready = 1'b0;
    repeat (10) @(negedge clk);
    s0 = tx_seen.size(); t0 = tv_cycles;
    fork
      apb_xfer(1'b1, TX_FIFO, 32'h0000005A, 3'b000, rd, se, n);
      begin repeat (10) @(negedge clk); tx_axis_tready = 1'b1; end
    join
    check_eq("txfull_wait", n, SLVERR_EN ? 1 : 9);
    check_eq("txfull_slverr", se, SLVERR_EN);
    check_eq("txfull_beats", tx_seen.size() - s0, SLVERR_EN ? 0 : 1);
    check_eq("txfull_tvalid_cycles", tv_cycles - t0, SLVERR_EN ? 0 : 8);
    check_eq("txfull_tdata", tx_seen[tx_seen.size()-1], SLVERR_EN ? 8'hA5 : 8'h5A);
    settle();

    // RX read with data, then while empty.
    push_rx(8'h3C);
    rd_rx();
    rd_rx();

    // Sticky errors: set/clear, and a pulse on the clearing edge survives.
    pulse_err(1);
    rd_stat(3'b000);
    rd_stat(3'b000);
    rd_stat(3'b001);
    rd_stat(3'b000);

    // Control bits and interrupt.
    wr_ctrl(3'b111);
    rd_ctrl();
    push_rx(8'h11);
    wr_ctrl(3'b000);
    rd_rx();

    // Reset while a TX beat is stalled.
    push_rx(8'h22);
    wr_ctrl(3'b001);
    s0 = tx_seen.size();
    tx_axis_tready = 1'b0;
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = TX_FIFO; pwdata = 32'h77;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check_eq("txwait_tvalid", tx_axis_tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_tvalid", tx_axis_tvalid, 1'b0);
    check_eq("arst_pready", pready, 1'b0);
    check_eq("arst_irq", irq, 1'b0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_axis_tready = 1'b1;
    m_irq_en = 1'b0; m_err = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("arst_no_beat", tx_seen.size() - s0, 0);
    wr_tx(32'h0000003E);
    rd_ctrl();
    rd_rx();

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      rx_fifo_full  = 1'($urandom_range(0, 1));
      tx_fifo_empty = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: if (rx_q.size() < 4) push_rx(8'($urandom));
        1: rd_rx();
        2: wr_tx($urandom);
        3: begin
          tx_axis_tready = 1'($urandom_range(0, 1));
          rd_stat(3'($urandom_range(0, 7)) & {3{1'($urandom_range(0, 1))}});
          tx_axis_tready = 1'b1;
        end
        4: wr_ctrl(3'($urandom_range(0, 7)));
        5: rd_ctrl();
        6: pulse_err($urandom_range(0, 2));
        default: bad_op($urandom_range(0, 4));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
